// File: rtl/ch_health_pkg.sv
// Shared health-controller types: FSM state encoding and default tuning constants.
package ch_health_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    IFRAME,
    DEAD
  } state_t;

  localparam int unsigned MAX_HP_D   = 3;
  localparam int unsigned IFRAME_D   = 60;
  localparam int unsigned BLINK_SH_D = 2;

  // Channel index width; a single channel still gets a one-bit index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ch_health_hit_arb.sv
// Fixed-priority hazard arbiter: lowest-index channel with hit set and nonzero damage wins.
module hit_arb
  import ch_health_pkg::*;
#(
  parameter int unsigned N_HAZ = 6,
  parameter int unsigned DMG_W = 2
) (
  input  logic [N_HAZ-1:0][DMG_W-1:0] dmg,
  input  logic [N_HAZ-1:0]            hit,
  output logic                        valid,
  output logic [idx_w(N_HAZ)-1:0]     idx,
  output logic [DMG_W-1:0]            damage
);

  localparam int unsigned IW = idx_w(N_HAZ);

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    damage = '0;
    for (int unsigned i = 0; i < N_HAZ; i++) begin
      if (!valid && hit[i] && (dmg[i] != '0)) begin
        valid  = 1'b1;
        idx    = IW'(i);
        damage = dmg[i];
      end
    end
  end

endmodule

// File: rtl/ch_health.sv
// Player health controller: damage arbitration, invulnerability window with blink, death and respawn.
module ch_health #(
  parameter int unsigned N_HAZ    = 6,
  parameter int unsigned HP_W     = 3,
  parameter int unsigned MAX_HP   = ch_health_pkg::MAX_HP_D,
  parameter int unsigned DMG_W    = 2,
  parameter int unsigned IFRAME   = ch_health_pkg::IFRAME_D,
  parameter int unsigned BLINK_SH = ch_health_pkg::BLINK_SH_D
) (
  input  logic                                   frame_clk,
  input  logic                                   Reset_n,
  input  logic [N_HAZ-1:0]                       hit,
  input  logic [N_HAZ-1:0][DMG_W-1:0]            dmg,
  input  logic                                   heal,
  input  logic                                   respawn,
  output logic [HP_W-1:0]                        hp,
  output logic                                   dead,
  output logic                                   invuln,
  output logic                                   visible,
  output logic                                   hurt_pulse,
  output logic [ch_health_pkg::idx_w(N_HAZ)-1:0] hit_src
);

  import ch_health_pkg::*;

  localparam int unsigned IW = idx_w(N_HAZ);
  localparam int unsigned TW = $clog2(IFRAME + 1);
  localparam int unsigned SW = ((HP_W > DMG_W) ? HP_W : DMG_W) + 1;
  localparam logic [HP_W-1:0] FULL  = HP_W'(MAX_HP);
  localparam logic [TW-1:0]   TLOAD = TW'(IFRAME - 1);

  if (N_HAZ < 1 || N_HAZ > 16) begin : g_bad_nhaz
    $error("N_HAZ out of range 1..16");
  end
  if (MAX_HP < 1 || MAX_HP > (2**HP_W) - 1) begin : g_bad_hp
    $error("MAX_HP out of range for HP_W");
  end
  if (IFRAME < 1 || BLINK_SH >= TW) begin : g_bad_iframe
    $error("IFRAME must be >= 1 and BLINK_SH must index the timer");
  end

  state_t          state, state_n;
  logic [HP_W-1:0] hp_n, hp_sub, hp_inc;
  logic [TW-1:0]   timer, timer_n;
  logic            hurt_n;
  logic [IW-1:0]   src_n;
  logic            win;
  logic [IW-1:0]   win_idx;
  logic [DMG_W-1:0] win_dmg;
  logic [SW-1:0]   diff;

  hit_arb #(
    .N_HAZ(N_HAZ),
    .DMG_W(DMG_W)
  ) u_arb (
    .dmg   (dmg),
    .hit   (hit),
    .valid (win),
    .idx   (win_idx),
    .damage(win_dmg)
  );

  // One extra bit catches the borrow so the result clamps at zero instead of wrapping.
  assign diff   = SW'(hp) - SW'(win_dmg);
  assign hp_sub = diff[SW-1] ? '0 : diff[HP_W-1:0];
  assign hp_inc = (hp < FULL) ? hp + HP_W'(1) : hp;

  always_comb begin
    state_n = state;
    hp_n    = hp;
    timer_n = timer;
    hurt_n  = 1'b0;
    src_n   = hit_src;
    case (state)
      ALIVE: begin
        if (win) begin
          hp_n   = hp_sub;
          src_n  = win_idx;
          hurt_n = 1'b1;
          if (hp_sub == '0) begin
            state_n = DEAD;
          end else begin
            state_n = ch_health_pkg::IFRAME;
            timer_n = TLOAD;
          end
        end else if (heal) begin
          hp_n = hp_inc;
        end
      end
      ch_health_pkg::IFRAME: begin
        if (heal) hp_n = hp_inc;
        if (timer == '0) state_n = ALIVE;
        else             timer_n = timer - TW'(1);
      end
      DEAD: begin
        if (respawn) begin
          state_n = ALIVE;
          hp_n    = FULL;
          timer_n = '0;
        end
      end
      default: state_n = ALIVE;
    endcase
  end

  // Flags are derived from the next state so every output is a register.
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state      <= ALIVE;
      hp         <= FULL;
      timer      <= '0;
      hurt_pulse <= 1'b0;
      hit_src    <= '0;
      dead       <= 1'b0;
      invuln     <= 1'b0;
      visible    <= 1'b1;
    end else begin
      state      <= state_n;
      hp         <= hp_n;
      timer      <= timer_n;
      hurt_pulse <= hurt_n;
      hit_src    <= src_n;
      dead       <= (state_n == DEAD);
      invuln     <= (state_n == ch_health_pkg::IFRAME);
      visible    <= (state_n == ch_health_pkg::IFRAME) ? ~timer_n[BLINK_SH] : 1'b1;
    end
  end

endmodule

// File: tb/tb_ch_health.sv
// Scoreboard bench for ch_health: default instance plus an N_HAZ=1, MAX_HP=7 instance.
module tb_ch_health;

  typedef struct {
    int at; int u; int hp; int dead; int inv; int vis; int hurt; int src;
  } snap_t;
  typedef struct {
    int at; int hp; int src;
  } hurt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_n;
  logic [5:0]      hit0;
  logic [5:0][1:0] dmg0;
  logic            heal0, resp0;
  logic [2:0]      hp0, src0;
  logic            dead0, inv0, vis0, hurt0;

  logic [0:0]      hit1;
  logic [0:0][1:0] dmg1;
  logic            heal1, resp1;
  logic [2:0]      hp1;
  logic [0:0]      src1;
  logic            dead1, inv1, vis1, hurt1;

  ch_health u0 (
    .frame_clk(clk), .Reset_n(rst_n), .hit(hit0), .dmg(dmg0), .heal(heal0),
    .respawn(resp0), .hp(hp0), .dead(dead0), .invuln(inv0), .visible(vis0),
    .hurt_pulse(hurt0), .hit_src(src0)
  );

  ch_health #(.N_HAZ(1), .HP_W(3), .MAX_HP(7)) u1 (
    .frame_clk(clk), .Reset_n(rst_n), .hit(hit1), .dmg(dmg1), .heal(heal1),
    .respawn(resp1), .hp(hp1), .dead(dead1), .invuln(inv1), .visible(vis1),
    .hurt_pulse(hurt1), .hit_src(src1)
  );

  int    checks = 0;
  int    errors = 0;
  snap_t sq[$];
  hurt_t hq[$];
  snap_t s;
  hurt_t h;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic snap(input int u, input int at, input int hp, input int dead,
                      input int inv, input int vis, input int hurt, input int src);
    snap_t e;
    e.at = at; e.u = u; e.hp = hp; e.dead = dead; e.inv = inv;
    e.vis = vis; e.hurt = hurt; e.src = src;
    sq.push_back(e);
  endtask

  task automatic hurt_exp(input int at, input int hp, input int src);
    hurt_t e;
    e.at = at; e.hp = hp; e.src = src;
    hq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upto(input int c);
    while (cyc < c) step();
  endtask

  // Monitor: compares state snapshots due this frame and every hurt pulse of u0.
  always @(negedge clk) begin
    for (int i = sq.size() - 1; i >= 0; i--) begin
      if (sq[i].at <= cyc) begin
        s = sq[i];
        sq.delete(i);
        if (s.at < cyc) chk("snap_due", cyc, s.at);
        else if (s.u == 0) begin
          chk("u0.hp", hp0, s.hp);       chk("u0.dead", dead0, s.dead);
          chk("u0.invuln", inv0, s.inv); chk("u0.visible", vis0, s.vis);
          chk("u0.hurt", hurt0, s.hurt); chk("u0.hit_src", src0, s.src);
        end else begin
          chk("u1.hp", hp1, s.hp);       chk("u1.dead", dead1, s.dead);
          chk("u1.invuln", inv1, s.inv); chk("u1.visible", vis1, s.vis);
          chk("u1.hurt", hurt1, s.hurt); chk("u1.hit_src", src1, s.src);
        end
      end
    end
    if (hurt0 === 1'b1) begin
      if (hq.size() == 0) chk("hurt_unexpected", 1, 0);
      else begin
        h = hq.pop_front();
        chk("hurt_cycle", cyc, h.at);
        chk("hurt_hp", hp0, h.hp);
        chk("hurt_src", src0, h.src);
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog at cycle %0d: got timeout expected completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int t;
    rst_n = 1'b0;
    hit0 = '0; dmg0 = '0; heal0 = 1'b0; resp0 = 1'b0;
    hit1 = '0; dmg1 = '0; heal1 = 1'b0; resp1 = 1'b0;
    step();
    snap(0, cyc + 1, 3, 0, 0, 1, 0, 0);
    snap(1, cyc + 1, 7, 0, 0, 1, 0, 0);
    step();
    rst_n = 1'b1;
    step();

    // Single hit, blink pattern, heal inside the invulnerability window
    t = cyc;
    hit0[2] = 1'b1; dmg0[2] = 2'd1;
    hurt_exp(t + 1, 2, 2);
    snap(0, t + 1, 2, 0, 1, 1, 1, 2);
    snap(0, t + 2, 2, 0, 1, 1, 0, 2);
    snap(0, t + 4, 2, 0, 1, 1, 0, 2);
    snap(0, t + 5, 2, 0, 1, 0, 0, 2);
    snap(0, t + 8, 2, 0, 1, 0, 0, 2);
    snap(0, t + 9, 2, 0, 1, 1, 0, 2);
    step();
    hit0 = '0; dmg0 = '0;
    upto(t + 10);
    heal0 = 1'b1;
    snap(0, t + 11, 3, 0, 1, 1, 0, 2);
    snap(0, t + 12, 3, 0, 1, 1, 0, 2);
    step();
    step();
    heal0 = 1'b0;
    snap(0, t + 60, 3, 0, 1, 1, 0, 2);
    snap(0, t + 61, 3, 0, 0, 1, 0, 2);
    upto(t + 61);

    // Priority: ch0 has zero damage, ch1 beats ch4; held hits ignored while invulnerable
    t = cyc;
    hit0[0] = 1'b1; dmg0[0] = 2'd0;
    hit0[1] = 1'b1; dmg0[1] = 2'd2;
    hit0[4] = 1'b1; dmg0[4] = 2'd1;
    hurt_exp(t + 1, 1, 1);
    snap(0, t + 1, 1, 0, 1, 1, 1, 1);
    snap(0, t + 2, 1, 0, 1, 1, 0, 1);
    step();
    step();
    hit0 = '0; dmg0 = '0;
    snap(0, t + 61, 1, 0, 0, 1, 0, 1);
    upto(t + 61);

    // Overkill clamps at zero, dead ignores hit/heal, respawn beats hit
    t = cyc;
    hit0[3] = 1'b1; dmg0[3] = 2'd3;
    hurt_exp(t + 1, 0, 3);
    snap(0, t + 1, 0, 1, 0, 1, 1, 3);
    step();
    hit0 = '0; dmg0 = '0;
    hit0[0] = 1'b1; dmg0[0] = 2'd1; heal0 = 1'b1;
    snap(0, t + 2, 0, 1, 0, 1, 0, 3);
    step();
    hit0 = '0; dmg0 = '0; heal0 = 1'b0;
    hit0[5] = 1'b1; dmg0[5] = 2'd3; resp0 = 1'b1;
    snap(0, t + 3, 3, 0, 0, 1, 0, 3);
    step();
    hit0 = '0; dmg0 = '0; heal0 = 1'b1;
    snap(0, t + 4, 3, 0, 0, 1, 0, 3);
    step();
    resp0 = 1'b0; heal0 = 1'b0;

    // Hazard held continuously: re-hit on the first frame back in ALIVE
    t = cyc;
    hit0[2] = 1'b1; dmg0[2] = 2'd1;
    hurt_exp(t + 1, 2, 2);
    hurt_exp(t + 62, 1, 2);
    hurt_exp(t + 123, 0, 2);
    snap(0, t + 61, 2, 0, 0, 1, 0, 2);
    snap(0, t + 62, 1, 0, 1, 1, 1, 2);
    snap(0, t + 123, 0, 1, 0, 1, 1, 2);
    upto(t + 123);
    hit0 = '0; dmg0 = '0;
    resp0 = 1'b1;
    snap(0, t + 124, 3, 0, 0, 1, 0, 2);
    step();
    resp0 = 1'b0;

    // Heal with hit: damage only; then reset mid-window on both instances
    t = cyc;
    hit0[0] = 1'b1; dmg0[0] = 2'd1; heal0 = 1'b1;
    hit1[0] = 1'b1; dmg1[0] = 2'd3;
    hurt_exp(t + 1, 2, 0);
    snap(0, t + 1, 2, 0, 1, 1, 1, 0);
    snap(1, t + 1, 4, 0, 1, 1, 1, 0);
    step();
    hit0 = '0; dmg0 = '0; heal0 = 1'b0; hit1 = '0; dmg1 = '0;
    snap(0, t + 30, 2, 0, 1, 0, 0, 0);
    snap(1, t + 30, 4, 0, 1, 0, 0, 0);
    upto(t + 30);
    rst_n = 1'b0;
    snap(0, t + 31, 3, 0, 0, 1, 0, 0);
    snap(1, t + 31, 7, 0, 0, 1, 0, 0);
    step();
    rst_n = 1'b1;

    // Accepts a hit immediately after reset
    t = cyc;
    hit0[1] = 1'b1; dmg0[1] = 2'd1;
    hurt_exp(t + 1, 2, 1);
    snap(0, t + 1, 2, 0, 1, 1, 1, 1);
    step();
    hit0 = '0; dmg0 = '0;
    upto(t + 4);

    chk("snap_pending", sq.size(), 0);
    chk("hurt_pending", hq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
